// File: rtl/fp_conv_pipe.sv
// FP32 <-> 32-bit integer conversion with RISC-V rounding/flags and an elastic output pipe.
// Define FP_CONV_UNSIGNED_EN to honour signed_i; otherwise every conversion is signed.
module fp_conv_pipe #(
   parameter int NUM_STAGES = 1,
   parameter int TAG_WIDTH  = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic                 f2i_i,
   input  logic                 signed_i,
   input  logic [2:0]           rnd_i,
   input  logic [31:0]          opa_i,
   input  logic [TAG_WIDTH-1:0] tag_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [31:0]          res_o,
   output logic [4:0]           status_o,
   output logic [TAG_WIDTH-1:0] tag_o,
   output logic                 busy_o
);

   localparam int PW = 32 + 5 + TAG_WIDTH;

   function automatic logic rnd_inc(input logic [2:0] rnd, input logic sign,
                                    input logic lsb, input logic rbit, input logic sticky);
      logic inc;
      case (rnd)
         3'd1:    inc = 1'b0;
         3'd2:    inc = sign & (rbit | sticky);
         3'd3:    inc = ~sign & (rbit | sticky);
         3'd4:    inc = rbit;
         default: inc = rbit & (sticky | lsb);
      endcase
      return inc;
   endfunction

   function automatic logic [4:0] lzc32(input logic [31:0] x);
      logic [4:0] n;
      n = 5'd0;
      for (int i = 0; i < 32; i++) begin
         if (x[i]) n = 5'(31 - i);
      end
      return n;
   endfunction

   logic w_uns;
`ifdef FP_CONV_UNSIGNED_EN
   assign w_uns = ~signed_i;
`else
   logic w_unused_signed;
   assign w_uns           = 1'b0;
   assign w_unused_signed = signed_i;
`endif

   logic        w_fs, w_fnan, w_fbig, w_fsmall, w_frbit, w_fstk, w_finc;
   logic        w_fovf_p, w_fovf_n, w_f2i_nv, w_f2i_nx;
   logic [7:0]  w_fe, w_feeff, w_fshamt;
   logic [22:0] w_fm;
   logic [23:0] w_fsig;
   logic [63:0] w_ffix;
   logic [31:0] w_fimag, w_f2i_res;
   logic [32:0] w_fround;

   // Magnitude as 32.32 fixed point; exponents below 118 cannot reach the round bit.
   always_comb begin
      w_fs     = opa_i[31];
      w_fe     = opa_i[30:23];
      w_fm     = opa_i[22:0];
      w_fnan   = (w_fe == 8'hFF) && (w_fm != 23'd0);
      w_feeff  = (w_fe == 8'd0) ? 8'd1 : w_fe;
      w_fsig   = {(w_fe != 8'd0), w_fm};
      w_fbig   = w_feeff > 8'd158;
      w_fsmall = w_feeff < 8'd118;
      w_fshamt = w_feeff - 8'd118;
      w_ffix   = w_fsmall ? 64'd0 : ({40'd0, w_fsig} << w_fshamt);
      w_fimag  = w_ffix[63:32];
      w_frbit  = w_ffix[31];
      w_fstk   = w_fsmall ? (w_fsig != 24'd0) : (w_ffix[30:0] != 31'd0);
      w_finc   = rnd_inc(rnd_i, w_fs, w_fimag[0], w_frbit, w_fstk);
      w_fround = {1'b0, w_fimag} + {32'd0, w_finc};

      w_fovf_p = 1'b0;
      w_fovf_n = 1'b0;
      if (w_fnan) begin
         w_fovf_p = 1'b1;
      end else if (w_fbig) begin
         w_fovf_p = ~w_fs;
         w_fovf_n = w_fs;
      end else if (w_uns) begin
         w_fovf_p = ~w_fs & w_fround[32];
         w_fovf_n = w_fs & (w_fround != 33'd0);
      end else begin
         w_fovf_p = ~w_fs & (w_fround > 33'h07FFFFFFF);
         w_fovf_n = w_fs & (w_fround > 33'h080000000);
      end

      w_f2i_res = w_fs ? (~w_fround[31:0] + 32'd1) : w_fround[31:0];
      w_f2i_nv  = 1'b0;
      w_f2i_nx  = w_frbit | w_fstk;
      if (w_fovf_p) begin
         w_f2i_res = w_uns ? 32'hFFFFFFFF : 32'h7FFFFFFF;
         w_f2i_nv  = 1'b1;
         w_f2i_nx  = 1'b0;
      end else if (w_fovf_n) begin
         w_f2i_res = w_uns ? 32'h00000000 : 32'h80000000;
         w_f2i_nv  = 1'b1;
         w_f2i_nx  = 1'b0;
      end
   end

   logic        w_is, w_iinc, w_i2f_nx;
   logic [4:0]  w_ilz;
   logic [31:0] w_imag, w_inorm, w_i2f_res;
   logic [7:0]  w_iexp;
   logic [30:0] w_ipack;

   // Rounding adds into {exp, mantissa} so a mantissa carry bumps the exponent.
   always_comb begin
      w_is      = ~w_uns & opa_i[31];
      w_imag    = w_is ? (~opa_i + 32'd1) : opa_i;
      w_ilz     = lzc32(w_imag);
      w_inorm   = w_imag << w_ilz;
      w_iexp    = 8'd158 - {3'd0, w_ilz};
      w_iinc    = rnd_inc(rnd_i, w_is, w_inorm[8], w_inorm[7], w_inorm[6:0] != 7'd0);
      w_ipack   = {w_iexp, w_inorm[30:8]} + {30'd0, w_iinc};
      w_i2f_res = w_inorm[31] ? {w_is, w_ipack} : 32'd0;
      w_i2f_nx  = w_inorm[31] & (w_inorm[7:0] != 8'd0);
   end

   logic [31:0]   w_res;
   logic [4:0]    w_status;
   logic [PW-1:0] w_payload;

   assign w_res     = f2i_i ? w_f2i_res : w_i2f_res;
   assign w_status  = f2i_i ? {w_f2i_nv, 3'b000, w_f2i_nx} : {4'b0000, w_i2f_nx};
   assign w_payload = {w_res, w_status, tag_i};

   generate
      if (NUM_STAGES == 0) begin : g_comb
         logic w_unused_pipe;
         assign w_unused_pipe = clk_i ^ rst_ni ^ flush_i;
         assign out_valid_o   = in_valid_i;
         assign in_ready_o    = out_ready_i;
         assign {res_o, status_o, tag_o} = w_payload;
         assign busy_o        = 1'b0;
      end else begin : g_pipe
         logic [NUM_STAGES-1:0]         r_valid;
         logic [NUM_STAGES-1:0][PW-1:0] r_data;
         logic [NUM_STAGES-1:0]         w_rdy;
         logic [NUM_STAGES-1:0]         w_vin;
         logic [NUM_STAGES-1:0][PW-1:0] w_din;

         // Ready folded from the output back so no stage bubbles under drain.
         always_comb begin
            logic acc;
            acc      = out_ready_i;
            w_vin[0] = in_valid_i;
            w_din[0] = w_payload;
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
               acc      = ~r_valid[k] | acc;
               w_rdy[k] = acc;
            end
            for (int k = 1; k < NUM_STAGES; k++) begin
               w_vin[k] = r_valid[k-1];
               w_din[k] = r_data[k-1];
            end
         end

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               r_valid <= '0;
               r_data  <= '0;
            end else if (flush_i) begin
               r_valid <= '0;
            end else begin
               for (int k = 0; k < NUM_STAGES; k++) begin
                  if (w_rdy[k]) begin
                     r_valid[k] <= w_vin[k];
                     if (w_vin[k]) r_data[k] <= w_din[k];
                  end
               end
            end
         end

         assign in_ready_o  = w_rdy[0] & ~flush_i;
         assign out_valid_o = r_valid[NUM_STAGES-1];
         assign {res_o, status_o, tag_o} = r_data[NUM_STAGES-1];
         assign busy_o      = |r_valid;
      end
   endgenerate

endmodule

// File: tb/tb_fp_conv_pipe.sv
// Directed bench for fp_conv_pipe: one 1-stage and one 3-stage instance.
module tb_fp_conv_pipe;
   localparam int TW = 8;

   typedef struct {
      logic [31:0] op;
      logic        sg;
      logic [2:0]  rm;
      logic [31:0] res;
      logic [4:0]  st;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          f2i = 1'b1;
   logic          sgn = 1'b1;
   logic [2:0]    rnd = 3'd0;
   logic [31:0]   opa = 32'd0;
   logic [TW-1:0] tag = '0;

   logic          v1 = 1'b0, ordy1 = 1'b1;
   logic          in_ready1, out_valid1, busy1;
   logic [31:0]   res1;
   logic [4:0]    st1;
   logic [TW-1:0] tag1;

   logic          v3 = 1'b0, ordy3 = 1'b1;
   logic          in_ready3, out_valid3, busy3;
   logic [31:0]   res3;
   logic [4:0]    st3;
   logic [TW-1:0] tag3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fp_conv_pipe #(.NUM_STAGES(1), .TAG_WIDTH(TW)) u_d1 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .in_valid_i(v1), .in_ready_o(in_ready1),
      .f2i_i(f2i), .signed_i(sgn), .rnd_i(rnd), .opa_i(opa), .tag_i(tag),
      .out_valid_o(out_valid1), .out_ready_i(ordy1),
      .res_o(res1), .status_o(st1), .tag_o(tag1), .busy_o(busy1)
   );

   fp_conv_pipe #(.NUM_STAGES(3), .TAG_WIDTH(TW)) u_d3 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .in_valid_i(v3), .in_ready_o(in_ready3),
      .f2i_i(f2i), .signed_i(sgn), .rnd_i(rnd), .opa_i(opa), .tag_i(tag),
      .out_valid_o(out_valid3), .out_ready_i(ordy3),
      .res_o(res3), .status_o(st3), .tag_o(tag3), .busy_o(busy3)
   );

   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if (out_valid1 !== 1'b0 || busy1 !== 1'b0 || res1 !== 32'd0 || st1 !== 5'd0 || tag1 !== '0) begin
         n_fail++;
         $display("FAIL reset_d1: v=%b busy=%b res=%h st=%h tag=%h, expected all zero",
                  out_valid1, busy1, res1, st1, tag1);
      end else $display("reset_d1 outputs zero");
      n_checks++;
      if (out_valid3 !== 1'b0 || busy3 !== 1'b0 || res3 !== 32'd0 || st3 !== 5'd0 || tag3 !== '0) begin
         n_fail++;
         $display("FAIL reset_d3: v=%b busy=%b res=%h st=%h tag=%h, expected all zero",
                  out_valid3, busy3, res3, st3, tag3);
      end else $display("reset_d3 outputs zero");
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (in_ready1 !== 1'b1 || in_ready3 !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: in_ready1=%b in_ready3=%b, expected 1 1", in_ready1, in_ready3);
      end else $display("reset_ready both 1");
   endtask

   task automatic test_f2i();
      vec_t tv [16];
      tv[0]  = '{32'h3F800000, 1'b1, 3'd0, 32'h00000001, 5'h00};
      tv[1]  = '{32'h40200000, 1'b1, 3'd0, 32'h00000002, 5'h01};
      tv[2]  = '{32'h40200000, 1'b1, 3'd4, 32'h00000003, 5'h01};
      tv[3]  = '{32'h40200000, 1'b1, 3'd7, 32'h00000002, 5'h01};
      tv[4]  = '{32'h40200000, 1'b1, 3'd3, 32'h00000003, 5'h01};
      tv[5]  = '{32'hC0200000, 1'b1, 3'd2, 32'hFFFFFFFD, 5'h01};
      tv[6]  = '{32'hC0200000, 1'b1, 3'd1, 32'hFFFFFFFE, 5'h01};
      tv[7]  = '{32'h7FC00000, 1'b1, 3'd0, 32'h7FFFFFFF, 5'h10};
      tv[8]  = '{32'h4F000000, 1'b1, 3'd1, 32'h7FFFFFFF, 5'h10};
      tv[9]  = '{32'hCF000000, 1'b1, 3'd1, 32'h80000000, 5'h00};
      tv[10] = '{32'hFF800000, 1'b1, 3'd0, 32'h80000000, 5'h10};
      tv[11] = '{32'h00000001, 1'b1, 3'd3, 32'h00000001, 5'h01};
      tv[12] = '{32'hBE800000, 1'b0, 3'd0, 32'h00000000, 5'h01};
`ifdef FP_CONV_UNSIGNED_EN
      tv[13] = '{32'hBF800000, 1'b0, 3'd0, 32'h00000000, 5'h10};
      tv[14] = '{32'h7FC00000, 1'b0, 3'd0, 32'hFFFFFFFF, 5'h10};
`else
      tv[13] = '{32'hBF800000, 1'b0, 3'd0, 32'hFFFFFFFF, 5'h00};
      tv[14] = '{32'h7FC00000, 1'b0, 3'd0, 32'h7FFFFFFF, 5'h10};
`endif
      tv[15] = '{32'h80000001, 1'b1, 3'd2, 32'hFFFFFFFF, 5'h01};
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         f2i = 1'b1; sgn = tv[i].sg; rnd = tv[i].rm; opa = tv[i].op; tag = TW'(i);
         v1 = 1'b1; ordy1 = 1'b1;
         @(posedge clk);
         #1;
         v1 = 1'b0;
         n_checks++;
         if (out_valid1 !== 1'b1 || res1 !== tv[i].res || st1 !== tv[i].st || tag1 !== TW'(i)) begin
            n_fail++;
            $display("FAIL f2i[%0d] op=%h rm=%0d: v=%b res=%h st=%h tag=%h, expected v=1 res=%h st=%h tag=%h",
                     i, tv[i].op, tv[i].rm, out_valid1, res1, st1, tag1, tv[i].res, tv[i].st, TW'(i));
         end else $display("f2i[%0d] op=%h rm=%0d res=%h st=%h", i, tv[i].op, tv[i].rm, res1, st1);
      end
   endtask

   task automatic test_i2f();
      vec_t tv [9];
      tv[0] = '{32'h01000001, 1'b1, 3'd0, 32'h4B800000, 5'h01};
      tv[1] = '{32'hFFFFFFFF, 1'b1, 3'd0, 32'hBF800000, 5'h00};
      tv[2] = '{32'h00000000, 1'b1, 3'd0, 32'h00000000, 5'h00};
      tv[3] = '{32'h80000000, 1'b1, 3'd0, 32'hCF000000, 5'h00};
      tv[4] = '{32'h01000001, 1'b1, 3'd3, 32'h4B800001, 5'h01};
      tv[5] = '{32'h7FFFFFFF, 1'b1, 3'd0, 32'h4F000000, 5'h01};
      tv[6] = '{32'h00000003, 1'b1, 3'd1, 32'h40400000, 5'h00};
`ifdef FP_CONV_UNSIGNED_EN
      tv[7] = '{32'hFFFFFFFF, 1'b0, 3'd0, 32'h4F800000, 5'h01};
`else
      tv[7] = '{32'hFFFFFFFF, 1'b0, 3'd0, 32'hBF800000, 5'h00};
`endif
      tv[8] = '{32'h7FFFFFFF, 1'b1, 3'd1, 32'h4EFFFFFF, 5'h01};
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         f2i = 1'b0; sgn = tv[i].sg; rnd = tv[i].rm; opa = tv[i].op; tag = TW'(8'h40 + i);
         v1 = 1'b1; ordy1 = 1'b1;
         @(posedge clk);
         #1;
         v1 = 1'b0;
         n_checks++;
         if (out_valid1 !== 1'b1 || res1 !== tv[i].res || st1 !== tv[i].st || tag1 !== TW'(8'h40 + i)) begin
            n_fail++;
            $display("FAIL i2f[%0d] op=%h rm=%0d: v=%b res=%h st=%h tag=%h, expected v=1 res=%h st=%h tag=%h",
                     i, tv[i].op, tv[i].rm, out_valid1, res1, st1, tag1, tv[i].res, tv[i].st, TW'(8'h40 + i));
         end else $display("i2f[%0d] op=%h rm=%0d res=%h st=%h", i, tv[i].op, tv[i].rm, res1, st1);
      end
   endtask

   task automatic test_stall();
      logic          f_t [3];
      logic [31:0]   op_t [3];
      logic [2:0]    rm_t [3];
      logic [31:0]   er_t [3];
      logic [4:0]    es_t [3];
      f_t[0] = 1'b1; op_t[0] = 32'h3F800000; rm_t[0] = 3'd0; er_t[0] = 32'h00000001; es_t[0] = 5'h00;
      f_t[1] = 1'b0; op_t[1] = 32'h00000003; rm_t[1] = 3'd1; er_t[1] = 32'h40400000; es_t[1] = 5'h00;
      f_t[2] = 1'b1; op_t[2] = 32'h40200000; rm_t[2] = 3'd4; er_t[2] = 32'h00000003; es_t[2] = 5'h01;
      @(negedge clk);
      ordy3 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         f2i = f_t[k]; sgn = 1'b1; rnd = rm_t[k]; opa = op_t[k]; tag = TW'(8'h10 + k);
         v3 = 1'b1;
         #1;
         n_checks++;
         if (in_ready3 !== 1'b1 || out_valid3 !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_fill[%0d]: in_ready=%b out_valid=%b, expected 1 0", k, in_ready3, out_valid3);
         end else $display("stall_fill[%0d] accepted op=%h", k, op_t[k]);
         @(negedge clk);
      end
      v3 = 1'b0;
      for (int c = 0; c < 5; c++) begin
         n_checks++;
         if (in_ready3 !== 1'b0 || out_valid3 !== 1'b1 || busy3 !== 1'b1 || res3 !== er_t[0] ||
             st3 !== es_t[0] || tag3 !== TW'(8'h10)) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: rdy=%b v=%b busy=%b res=%h st=%h tag=%h, expected 0 1 1 %h %h %h",
                     c, in_ready3, out_valid3, busy3, res3, st3, tag3, er_t[0], es_t[0], TW'(8'h10));
         end else $display("stall_hold[%0d] res=%h tag=%h", c, res3, tag3);
         @(negedge clk);
      end
      ordy3 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (out_valid3 !== 1'b1 || res3 !== er_t[k] || st3 !== es_t[k] || tag3 !== TW'(8'h10 + k)) begin
            n_fail++;
            $display("FAIL drain[%0d]: v=%b res=%h st=%h tag=%h, expected 1 %h %h %h",
                     k, out_valid3, res3, st3, tag3, er_t[k], es_t[k], TW'(8'h10 + k));
         end else $display("drain[%0d] res=%h tag=%h", k, res3, tag3);
         @(negedge clk);
      end
      n_checks++;
      if (out_valid3 !== 1'b0 || busy3 !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_empty: v=%b busy=%b, expected 0 0", out_valid3, busy3);
      end else $display("drain_empty pipe idle");
   endtask

   task automatic test_flush();
      @(negedge clk);
      ordy3 = 1'b0;
      for (int k = 0; k < 2; k++) begin
         f2i = 1'b1; sgn = 1'b1; rnd = 3'd0; opa = 32'h3F800000; tag = TW'(8'h21 + k);
         v3 = 1'b1;
         @(negedge clk);
      end
      v3 = 1'b0;
      n_checks++;
      if (busy3 !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_pre: busy=%b, expected 1", busy3);
      end else $display("flush_pre two entries held");
      flush = 1'b1; v3 = 1'b1; opa = 32'h40200000; tag = TW'(8'h33);
      #1;
      n_checks++;
      if (in_ready3 !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_ready: in_ready=%b, expected 0", in_ready3);
      end else $display("flush_ready in_ready low during flush");
      @(posedge clk);
      #1;
      flush = 1'b0; v3 = 1'b0; ordy3 = 1'b1;
      n_checks++;
      if (out_valid3 !== 1'b0 || busy3 !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_clear: v=%b busy=%b, expected 0 0", out_valid3, busy3);
      end else $display("flush_clear pipe empty");
      repeat (4) @(negedge clk);
      n_checks++;
      if (out_valid3 !== 1'b0 || busy3 !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_noaccept: v=%b busy=%b, expected 0 0", out_valid3, busy3);
      end else $display("flush_noaccept flush-cycle request dropped");
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      ordy3 = 1'b0;
      f2i = 1'b1; sgn = 1'b1; rnd = 3'd0; opa = 32'h40400000; tag = TW'(8'h55);
      v3 = 1'b1;
      @(negedge clk);
      v3 = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (out_valid3 !== 1'b1 || res3 !== 32'h00000003 || tag3 !== TW'(8'h55)) begin
         n_fail++;
         $display("FAIL areset_pre: v=%b res=%h tag=%h, expected 1 00000003 55", out_valid3, res3, tag3);
      end else $display("areset_pre res=%h tag=%h", res3, tag3);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid3 !== 1'b0 || busy3 !== 1'b0 || res3 !== 32'd0 || tag3 !== '0) begin
         n_fail++;
         $display("FAIL areset: v=%b busy=%b res=%h tag=%h, expected 0 0 0 0", out_valid3, busy3, res3, tag3);
      end else $display("areset entries discarded");
      @(negedge clk);
      rst_n = 1'b1;
      ordy3 = 1'b1;
   endtask

   initial begin
      test_reset();
      test_f2i();
      test_i2f();
      test_stall();
      test_flush();
      test_async_reset();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
